// File: rtl/qr_fixed_pkg.sv
// Shared fixed-point constants and FSM encoding for the QR datapath blocks.
// S1.14 operands/results and the sequential-unit state encoding live here.
package qr_fixed_pkg;

  localparam int QR_DATA_W = 16;
  localparam int QR_FRAC_W = 14;

  localparam logic signed [QR_DATA_W-1:0] QR_S114_MAX = 16'sh7FFF;
  localparam logic signed [QR_DATA_W-1:0] QR_S114_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } qr_state_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Rounds a wide signed accumulator back to DATA_W bits (half toward +inf)
// and clamps it to the signed DATA_W range, flagging any clamping.
module fixed_round_sat #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shr_s;

  // Round by adding half an LSB then arithmetic shift; clamp to the output range.
  always_comb begin
    sum_s  = acc + RND_HALF;
    shr_s  = sum_s >>> FRAC_W;
    result = shr_s[DATA_W-1:0];
    sat    = 1'b0;
    if (shr_s > RES_MAX) begin
      result = RES_MAX[DATA_W-1:0];
      sat    = 1'b1;
    end else if (shr_s < RES_MIN) begin
      result = RES_MIN[DATA_W-1:0];
      sat    = 1'b1;
    end else begin
      result = shr_s[DATA_W-1:0];
      sat    = 1'b0;
    end
  end

endmodule

// File: rtl/fixed_mult.sv
// Sequential S1.14 x 2.14 multiplier: radix-4 shift-add over DATA_W/2 cycles,
// then one round/saturate cycle; start/valid handshake with global enable.
module fixed_mult #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic              o_sat
);

  import qr_fixed_pkg::*;

  localparam int CNT_W = $clog2(DATA_W/2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W/2-1);

  qr_state_t                state_r, state_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;
  logic signed [ACC_W-1:0]  acc_r, acc_s;
  logic [DATA_W-1:0]        a_r, a_s;
  logic [DATA_W-1:0]        b_r, b_s;
  logic                     busy_r, busy_s;
  logic                     valid_r, valid_s;
  logic [DATA_W-1:0]        result_r, result_s;
  logic                     sat_r, sat_s;

  logic [1:0]               digit_s;
  logic signed [ACC_W-1:0]  a_ext_s;
  logic signed [ACC_W-1:0]  mult_s;
  logic signed [ACC_W-1:0]  pp_s;
  logic [DATA_W-1:0]        rs_result_s;
  logic                     rs_sat_s;

  fixed_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_round_sat (
    .acc    (acc_r),
    .result (rs_result_s),
    .sat    (rs_sat_s)
  );

  // Current radix-4 partial product: a * digit, aligned to the digit position.
  always_comb begin
    digit_s = b_r[{cnt_r, 1'b0} +: 2];
    a_ext_s = {{(ACC_W-DATA_W){a_r[DATA_W-1]}}, a_r};
    case (digit_s)
      2'd0:    mult_s = '0;
      2'd1:    mult_s = a_ext_s;
      2'd2:    mult_s = a_ext_s <<< 1;
      2'd3:    mult_s = a_ext_s + (a_ext_s <<< 1);
      default: mult_s = '0;
    endcase
    pp_s = mult_s <<< {cnt_r, 1'b0};
  end

  // Next-state and next-output logic for IDLE -> RUN -> FIN.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    acc_s    = acc_r;
    a_s      = a_r;
    b_s      = b_r;
    valid_s  = 1'b0;
    result_s = result_r;
    sat_s    = sat_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          a_s     = i_a;
          b_s     = i_b;
          acc_s   = '0;
          cnt_s   = '0;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_s = acc_r + pp_s;
        cnt_s = cnt_r + 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIN: begin
        result_s = rs_result_s;
        sat_s    = rs_sat_s;
        valid_s  = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; everything freezes while i_en is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= '0;
      sat_r    <= 1'b0;
    end else if (i_en) begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      acc_r    <= acc_s;
      a_r      <= a_s;
      b_r      <= b_s;
      busy_r   <= busy_s;
      valid_r  <= valid_s;
      result_r <= result_s;
      sat_r    <= sat_s;
    end
  end

  assign o_busy   = busy_r;
  assign o_valid  = valid_r;
  assign o_result = result_r;
  assign o_sat    = sat_r;

endmodule

// File: tb/tb_fixed_mult.sv
// Self-checking bench for fixed_mult: directed corner cases plus random
// operands against a plain-arithmetic reference of S1.14 x 2.14 -> S1.14.
module tb_fixed_mult;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = 16'h0000;
  logic [15:0] i_b = 16'h0000;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_result;
  logic        o_sat;

  int n_checks = 0;
  int n_errors = 0;

  fixed_mult dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_start  (i_start),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_sat    (o_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact product, +half LSB, floor-shift, clamp to 16-bit signed.
  function automatic logic [16:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'({16'h0000, b});
    r = (p + 64'sd8192) >>> 14;
    if (r > 64'sd32767)       return {1'b1, 16'h7FFF};
    else if (r < -64'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, r[15:0]};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Launch one multiply from an idle/valid cycle and wait for its o_valid.
  // drop_at/drop_len gate i_en off; extra_at pulses a start that must be ignored.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_lat, input int drop_at, input int drop_len,
                        input int extra_at);
    int n;
    int busy_n;
    logic [16:0] exp;
    exp = ref_mult(a, b);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    i_en = 1'b1;
    tick();
    i_start = 1'b0;
    i_a = $urandom();
    i_b = $urandom();
    n = 0;
    busy_n = 0;
    while (!o_valid && n < 40) begin
      if (o_busy) busy_n++;
      i_en = !(n >= drop_at && n < drop_at + drop_len);
      i_start = (n == extra_at);
      tick();
      n++;
    end
    i_start = 1'b0;
    i_en = 1'b1;
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_busy_cycles"}, busy_n, exp_lat);
    check_val({tag, "_busy_at_valid"}, o_busy, 1'b0);
    check_val({tag, "_result"}, o_result, exp[15:0]);
    check_val({tag, "_sat"}, o_sat, exp[16]);
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] held;

    tick();
    tick();
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_valid", o_valid, 1'b0);
    check_val("rst_result", o_result, 16'h0000);
    check_val("rst_sat", o_sat, 1'b0);
    i_rst = 1'b0;
    tick();

    // 1.0 * 1.0, then show o_valid holds while disabled and clears after
    run_op("one_x_one", 16'h4000, 16'h4000, 9, 99, 0, 99);
    check_val("one_x_one_exact", o_result, 16'h4000);
    i_en = 1'b0;
    tick();
    tick();
    check_val("valid_hold_dis", o_valid, 1'b1);
    i_en = 1'b1;
    tick();
    check_val("valid_clears", o_valid, 1'b0);
    check_val("result_held", o_result, 16'h4000);

    run_op("neg_half", 16'hC000, 16'h2000, 9, 99, 0, 99);
    check_val("neg_half_exact", o_result, 16'hE000);
    run_op("half_up", 16'h0001, 16'h2000, 9, 99, 0, 99);
    check_val("half_up_exact", o_result, 16'h0001);
    run_op("neg_half_lsb", 16'hFFFF, 16'h2000, 9, 99, 0, 99);
    check_val("neg_half_lsb_exact", o_result, 16'h0000);
    run_op("sat_pos", 16'h6000, 16'h8000, 9, 99, 0, 99);
    check_val("sat_pos_exact", {o_sat, o_result}, {1'b1, 16'h7FFF});
    run_op("sat_neg", 16'h8000, 16'hC000, 9, 99, 0, 99);
    check_val("sat_neg_exact", {o_sat, o_result}, {1'b1, 16'h8000});
    run_op("sat_neg_max", 16'h8000, 16'hFFFF, 9, 99, 0, 99);
    check_val("sat_neg_max_exact", {o_sat, o_result}, {1'b1, 16'h8000});

    // Enable gap of 3 clocks during RUN plus an ignored start while busy
    tick();
    run_op("en_gap", 16'h4000, 16'h6000, 12, 2, 3, 5);
    check_val("en_gap_exact", o_result, 16'h6000);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_valid) n++;
    end
    check_val("no_extra_valid", n, 0);
    check_val("idle_after_ignored", o_busy, 1'b0);

    // Back-to-back: the second start lands in the first o_valid cycle
    run_op("b2b_first", 16'h1234, 16'h5678, 9, 99, 0, 99);
    run_op("b2b_second", 16'h2000, 16'h4000, 9, 99, 0, 99);
    check_val("b2b_second_exact", o_result, 16'h2000);

    // Asynchronous reset with cnt at 4 aborts the operation
    held = o_result;
    check_val("pre_rst_nonzero", (held != 16'h0000), 1'b1);
    i_a = 16'h4000;
    i_b = 16'h4000;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 i_rst = 1'b1;
    #1;
    check_val("abort_busy", o_busy, 1'b0);
    check_val("abort_valid", o_valid, 1'b0);
    check_val("abort_result", o_result, 16'h0000);
    check_val("abort_sat", o_sat, 1'b0);
    tick();
    i_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_valid || o_busy) n++;
    end
    check_val("abort_quiet", n, 0);
    run_op("after_abort", 16'hC000, 16'h4000, 9, 99, 0, 99);

    // Random operands, biased toward the extremes every few draws
    for (int k = 0; k < 24; k++) begin
      ra = $urandom();
      rb = $urandom();
      if (k % 4 == 1) ra = (ra[0]) ? 16'h8000 : 16'h7FFF;
      if (k % 4 == 2) rb = (rb[0]) ? 16'hFFFF : 16'h0000;
      run_op("rand", ra, rb, 9, 99, 0, 99);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
